// File: rtl/busca_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package busca_pkg;

  typedef logic [7:0] endereco_t;

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    BUSCA  = 2'd1,
    PARADO = 2'd2
  } estado_busca_t;

  localparam endereco_t OP_PARADA_PADRAO   = 8'hE0;
  localparam endereco_t END_INICIAL_PADRAO = 8'd10;

  // PC increment; 8-bit arithmetic gives the 255 -> 0 wrap for free.
  function automatic endereco_t proximo_pc(input endereco_t pc);
    return endereco_t'(pc + 8'd1);
  endfunction

endpackage

// File: rtl/instrucao_memoria.sv
// 256x8 instruction memory: synchronous write on the rising edge, read on the falling edge.
module instrucao_memoria
  import busca_pkg::*;
(
  input  logic       clock,
  input  logic       escrita,
  input  endereco_t  end_escrita,
  input  logic [7:0] dado_escrita,
  input  endereco_t  endereco,
  output logic [7:0] dado
);

  logic [7:0] mem_q [256];
  logic [7:0] dado_q;

  always_ff @(posedge clock) begin
    if (escrita) begin
      mem_q[end_escrita] <= dado_escrita;
    end
  end

  // Falling-edge read so the byte is ready at the next rising edge.
  always_ff @(negedge clock) begin
    dado_q <= mem_q[endereco];
  end

  assign dado = dado_q;

endmodule

// File: rtl/controle_busca.sv
// Instruction-fetch sequencer: owns the PC, captures memory bytes into a one-entry
// valid/ready output register, and handles redirects, PC wrap and the halt opcode.
module controle_busca
  import busca_pkg::*;
#(
  parameter endereco_t   END_INICIAL = END_INICIAL_PADRAO,
  parameter endereco_t   OP_PARADA   = OP_PARADA_PADRAO,
  parameter int unsigned LARG_CONT   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  output endereco_t            endereco,
  input  logic [7:0]           instrucao,
  output logic [7:0]           instr_saida,
  output endereco_t            instr_pc,
  output logic                 instr_valida,
  input  logic                 instr_pronta,
  input  logic                 desvio_valido,
  input  endereco_t            desvio_endereco,
  output logic                 parado,
  output logic [LARG_CONT-1:0] contagem
);

  estado_busca_t        estado_q, estado_d;
  endereco_t            pc_q, pc_d;
  logic [7:0]           saida_q, saida_d;
  endereco_t            ipc_q, ipc_d;
  logic                 valida_q, valida_d;
  logic                 parado_q, parado_d;
  logic [LARG_CONT-1:0] cont_q, cont_d;
  logic                 transf;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIO;
      pc_q     <= END_INICIAL;
      saida_q  <= 8'd0;
      ipc_q    <= 8'd0;
      valida_q <= 1'b0;
      parado_q <= 1'b0;
      cont_q   <= '0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      saida_q  <= saida_d;
      ipc_q    <= ipc_d;
      valida_q <= valida_d;
      parado_q <= parado_d;
      cont_q   <= cont_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    saida_d  = saida_q;
    ipc_d    = ipc_q;
    valida_d = valida_q;
    parado_d = parado_q;
    cont_d   = cont_q;
    transf   = valida_q && instr_pronta;

    // A transfer on a redirect edge still belongs to the consumer and is counted.
    if (transf) begin
      cont_d = cont_q + LARG_CONT'(1);
    end

    if (desvio_valido) begin
      pc_d     = desvio_endereco;
      valida_d = 1'b0;
      estado_d = BUSCA;
      parado_d = 1'b0;
    end else begin
      case (estado_q)
        INICIO: estado_d = BUSCA;
        BUSCA: begin
          if (!valida_q || transf) begin
            saida_d  = instrucao;
            ipc_d    = pc_q;
            valida_d = 1'b1;
            // The halt opcode is captured but the PC stays on it.
            if (instrucao == OP_PARADA) begin
              estado_d = PARADO;
              parado_d = 1'b1;
            end else begin
              pc_d = proximo_pc(pc_q);
            end
          end
        end
        PARADO: begin
          if (transf) begin
            valida_d = 1'b0;
          end
        end
        default: estado_d = INICIO;
      endcase
    end
  end

  assign endereco     = pc_q;
  assign instr_saida  = saida_q;
  assign instr_pc     = ipc_q;
  assign instr_valida = valida_q;
  assign parado       = parado_q;
  assign contagem     = cont_q;

endmodule

// File: tb/tb_controle_busca.sv
// Directed bench for controle_busca with the instruction memory model and a transfer scoreboard.
module tb_controle_busca;
  import busca_pkg::*;

  logic        clock;
  logic        reset;
  endereco_t   endereco;
  logic [7:0]  instrucao;
  logic [7:0]  instr_saida;
  endereco_t   instr_pc;
  logic        instr_valida;
  logic        instr_pronta;
  logic        desvio_valido;
  endereco_t   desvio_endereco;
  logic        parado;
  logic [15:0] contagem;
  logic        escrita;
  endereco_t   end_escrita;
  logic [7:0]  dado_escrita;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_pushed = 0;
  logic [15:0] exp_q [$];

  controle_busca #(
    .END_INICIAL(8'd10),
    .OP_PARADA  (8'hE0),
    .LARG_CONT  (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .endereco       (endereco),
    .instrucao      (instrucao),
    .instr_saida    (instr_saida),
    .instr_pc       (instr_pc),
    .instr_valida   (instr_valida),
    .instr_pronta   (instr_pronta),
    .desvio_valido  (desvio_valido),
    .desvio_endereco(desvio_endereco),
    .parado         (parado),
    .contagem       (contagem)
  );

  instrucao_memoria mem (
    .clock       (clock),
    .escrita     (escrita),
    .end_escrita (end_escrita),
    .dado_escrita(dado_escrita),
    .endereco    (endereco),
    .dado        (instrucao)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] mem_val(input logic [7:0] a);
    case (a)
      8'd10:   return 8'h08;
      8'd11:   return 8'h10;
      8'd12:   return 8'h17;
      8'd14:   return 8'h15;
      8'd15:   return 8'h1A;
      8'd20:   return 8'h1D;
      8'd40:   return 8'h1D;
      8'd65:   return 8'hE0;
      default: return {a[6:0], 1'b1};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] a);
    exp_q.push_back({a, mem_val(a)});
    cnt_pushed++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] pc, input logic [7:0] ins);
    chk({tag, "_valid"}, 32'(instr_valida), 32'(v));
    chk({tag, "_pc"}, 32'(instr_pc), 32'(pc));
    chk({tag, "_instr"}, 32'(instr_saida), 32'(ins));
  endtask

  task automatic chk_sb(input string tag);
    chk({tag, "_sb_pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_contagem"}, 32'(contagem), 32'(cnt_pushed));
  endtask

  // Scoreboard: a transfer will occur at the next rising edge.
  always @(negedge clock) begin
    if (!reset && instr_valida && instr_pronta) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_xfer_pc", 32'(instr_pc), 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", 32'(instr_pc), 32'(e[15:8]));
        chk("sb_instr", 32'(instr_saida), 32'(e[7:0]));
      end
    end
  end

  // Release reset and stream (10,08),(11,10),(12,17).
  task automatic cenario_inicial();
    push(8'd10); push(8'd11); push(8'd12);
    reset = 1'b0;
    instr_pronta = 1'b1;
    step();
    chk("ini_c1_valid", 32'(instr_valida), 32'd0);
    step();
    chk_out("ini_c2", 1'b1, 8'd10, 8'h08);
    step();
    chk_out("ini_c3", 1'b1, 8'd11, 8'h10);
    step();
    chk_out("ini_c4", 1'b1, 8'd12, 8'h17);
    step();
    chk_sb("ini_end");
    chk("ini_cnt3", 32'(contagem), 32'd3);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    instr_pronta = 1'b0;
    desvio_valido = 1'b0;
    desvio_endereco = 8'd0;
    escrita = 1'b0;
    end_escrita = 8'd0;
    dado_escrita = 8'd0;
    #2;
    for (int a = 0; a < 256; a++) begin
      escrita = 1'b1;
      end_escrita = 8'(a);
      dado_escrita = mem_val(8'(a));
      step();
    end
    escrita = 1'b0;
    step();

    chk_out("rst", 1'b0, 8'd0, 8'd0);
    chk("rst_parado", 32'(parado), 32'd0);
    chk("rst_contagem", 32'(contagem), 32'd0);
    chk("rst_endereco", 32'(endereco), 32'd10);

    cenario_inicial();

    // Backpressure while (14,15) is held.
    push(8'd13);
    step();
    instr_pronta = 1'b0;
    chk_out("bp_load", 1'b1, 8'd14, 8'h15);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("bp_hold", 1'b1, 8'd14, 8'h15);
      chk("bp_endereco", 32'(endereco), 32'd15);
    end
    instr_pronta = 1'b1;
    for (int a = 14; a < 20; a++) push(8'(a));
    guard = 0;
    do begin
      step();
      guard++;
    end while (!(instr_valida && instr_pc == 8'd20) && guard < 20);
    instr_pronta = 1'b0;
    chk("bp_reach20_budget", 32'(guard), 32'd6);
    chk_out("bp_at20", 1'b1, 8'd20, 8'h1D);
    chk_sb("bp_end");

    // Redirect to 40 while (20,1D) is stalled.
    step();
    chk_out("rd_hold", 1'b1, 8'd20, 8'h1D);
    desvio_valido = 1'b1;
    desvio_endereco = 8'd40;
    step();
    desvio_valido = 1'b0;
    desvio_endereco = 8'($urandom);
    chk("rd_bubble_valid", 32'(instr_valida), 32'd0);
    chk("rd_endereco", 32'(endereco), 32'd40);
    chk_sb("rd_squash");
    step();
    chk_out("rd_target", 1'b1, 8'd40, 8'h1D);

    // Redirect to 60 on the same edge as the transfer of (40,1D).
    push(8'd40);
    instr_pronta = 1'b1;
    desvio_valido = 1'b1;
    desvio_endereco = 8'd60;
    step();
    desvio_valido = 1'b0;
    desvio_endereco = 8'($urandom);
    chk("rd60_valid", 32'(instr_valida), 32'd0);
    chk("rd60_endereco", 32'(endereco), 32'd60);
    chk_sb("rd60_xfer_counted");

    // Halt at 65.
    for (int a = 60; a <= 65; a++) push(8'(a));
    for (int i = 0; i < 6; i++) step();
    chk_out("halt_offer", 1'b1, 8'd65, 8'hE0);
    chk("halt_parado", 32'(parado), 32'd1);
    chk("halt_endereco", 32'(endereco), 32'd65);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_idle_valid", 32'(instr_valida), 32'd0);
      chk("halt_idle_endereco", 32'(endereco), 32'd65);
      chk("halt_idle_parado", 32'(parado), 32'd1);
    end
    chk_sb("halt_end");

    desvio_valido = 1'b1;
    desvio_endereco = 8'd10;
    step();
    desvio_valido = 1'b0;
    desvio_endereco = 8'($urandom);
    chk("resume_parado", 32'(parado), 32'd0);
    chk("resume_valid", 32'(instr_valida), 32'd0);
    chk("resume_endereco", 32'(endereco), 32'd10);
    push(8'd10);
    step();
    chk_out("resume_first", 1'b1, 8'd10, 8'h08);

    // Wrap: redirect to 254.
    desvio_valido = 1'b1;
    desvio_endereco = 8'd254;
    step();
    desvio_valido = 1'b0;
    push(8'd254); push(8'd255); push(8'd0); push(8'd1);
    for (int i = 0; i < 5; i++) step();
    instr_pronta = 1'b0;
    chk_out("wrap_held", 1'b1, 8'd2, mem_val(8'd2));
    chk("wrap_endereco", 32'(endereco), 32'd3);
    chk_sb("wrap_end");

    // Asynchronous reset mid-stall.
    step();
    chk_out("stall_pre_rst", 1'b1, 8'd2, mem_val(8'd2));
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 8'd0, 8'd0);
    chk("async_rst_parado", 32'(parado), 32'd0);
    chk("async_rst_contagem", 32'(contagem), 32'd0);
    chk("async_rst_endereco", 32'(endereco), 32'd10);
    step();
    cnt_pushed = 0;
    cenario_inicial();
    instr_pronta = 1'b0;
    step();
    step();
    chk_out("final_held", 1'b1, 8'd13, mem_val(8'd13));
    chk("final_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/controle_busca.md
Name: controle_busca

Overview:
Instruction-fetch sequencer for the 256x8 instruction memory (`instrucao_memoria`), which reads on the falling clock edge. It owns the program counter and drives the memory address. It captures the returned byte into a one-entry output register and offers it to the decoder with a valid/ready handshake. It also handles branch redirects, PC wrap-around and a halt opcode.

Parameters:
END_INICIAL, 8'd10, PC value loaded on reset (first program address).
OP_PARADA, 8'hE0, opcode that halts fetching once it is captured.
LARG_CONT, 16, width of the retired-instruction counter.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
endereco  out  8  address to the instruction memory; always equals the internal PC.
instrucao  in  8  memory data; valid at a rising edge for the address driven during the preceding cycle (the memory reads on the intervening falling edge).
instr_saida  out  8  captured instruction byte.
instr_pc  out  8  address from which instr_saida was fetched.
instr_valida  out  1  instr_saida/instr_pc hold a valid instruction.
instr_pronta  in  1  decoder accepts; a transfer occurs when instr_valida && instr_pronta at a rising edge.
desvio_valido  in  1  one-cycle redirect request.
desvio_endereco  in  8  redirect target.
parado  out  1  high while in PARADO.
contagem  out  LARG_CONT  count of completed transfers; wraps.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state=INICIO, pc=END_INICIAL, instr_valida=0, instr_saida=0, instr_pc=0, parado=0, contagem=0.
- States: INICIO, BUSCA, PARADO.
- INICIO:
  - Lasts exactly one cycle. It guarantees a falling edge has read MEM[pc]; nothing is captured.
  - Next state is BUSCA, or a redirect is applied if desvio_valido is high.
- BUSCA: output register is "free" if instr_valida=0, or if a transfer occurs this edge. When free:
  - instr_saida<=instrucao, instr_pc<=pc, instr_valida<=1.
  - pc<=pc+1, mod 256 (255 wraps to 0).
  - If instrucao==OP_PARADA, pc holds and the next state is PARADO.
- BUSCA, not free (valid && !pronta): all outputs and pc hold. Stall duration is unlimited.
- Transfer without reload (PARADO, or the cycle a redirect is applied): instr_valida<=0.
- PARADO:
  - No capture; pc holds; parado=1.
  - The halt instruction itself remains offered until transferred.
  - Leaves only via reset or redirect.
- Redirect (desvio_valido=1 in any non-reset state) has priority over capture and halt:
  - pc<=desvio_endereco.
  - instr_valida<=0; the held or incoming byte is squashed.
  - Next state is BUSCA, and parado<=0.
  - A transfer completing on the same edge still counts. The consumer owns that byte.
  - The first byte from the target appears valid one cycle later, so the redirect penalty is 1 bubble.
- contagem increments by 1 on every transfer, wraps at 2^LARG_CONT.
- Throughput is 1 instruction/cycle with instr_pronta held high. Latency is address-to-valid of 1 cycle.
- desvio_endereco is used only when desvio_valido=1; no X-propagation from it otherwise.

Decomposition:
- Package `busca_pkg`:
  - state enum `estado_busca_t` {INICIO, BUSCA, PARADO}.
  - Constants OP_PARADA_PADRAO=8'hE0 and END_INICIAL_PADRAO=8'd10.
  - Typedef `endereco_t` = logic [7:0].
- Single module, no sub-module. The PC-plus-output-register is too small to split.
- The bench instantiates `instrucao_memoria` alongside as the memory model.

Test Plan:
- Reset release, pronta=1, MEM[10]=08, MEM[11]=10, MEM[12]=17:
  - Valid first rises 2 cycles after reset falls.
  - Delivers (pc,instr) = (10,08), (11,10), (12,17) on consecutive cycles.
  - contagem=3.
- Backpressure: pronta=0 for 5 cycles while valid at (14,15):
  - Outputs and endereco=15 stay stable.
  - On pronta=1, delivers (14,15) then (15,1A); no loss or duplication.
- Redirect with desvio_endereco=40 while (20,1D) is held and pronta=0:
  - Next cycle valid=0.
  - Following cycle delivers (40,1D).
  - The squashed (20,1D) is not counted.
- Halt: run from 60 to 65 (MEM[65]=E0), pronta=1:
  - (65,E0) is delivered and parado=1.
  - Valid drops and endereco stays 65 for 10 cycles.
  - Then redirect to 10 clears parado and resumes with (10,08).
- Wrap: redirect to 254, pronta=1:
  - Delivers instr_pc 254, 255, 0, 1.
- Reset asserted mid-stall (valid=1, pronta=0), asynchronous between edges:
  - Outputs clear immediately.
  - After release, behaviour is identical to the first scenario.
